// File: rtl/mem_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_ctrl
// Description : Memory-side partner of a multicycle CPU. Services level-held
//               readM/writeM requests on a shared address/data bus with a
//               fixed access latency, holding a word-addressed backing array.
//               Read completion is signalled by a one-cycle inputReady pulse
//               (word driven on data), write completion by a one-cycle
//               ackOutput pulse.
// Ports       : clk          - system clock, rising edge
//               reset        - asynchronous active-high reset
//               readM        - read request, held until serviced
//               writeM       - write request, held until serviced
//               address      - word address, low ADDR_BITS bits used
//               data         - bidirectional bus, driven only for reads
//               inputReady   - one-cycle pulse, read data valid on data
//               ackOutput    - one-cycle pulse, write committed
//               busy         - high whenever the FSM is not idle
//               req_conflict - sticky flag, readM and writeM seen together
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_ctrl #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 readM,
  input  logic                 writeM,
  input  logic [WORD_SIZE-1:0] address,
  inout  wire  [WORD_SIZE-1:0] data,
  output logic                 inputReady,
  output logic                 ackOutput,
  output logic                 busy,
  output logic                 req_conflict
);

  localparam int         DEPTH     = 1 << ADDR_BITS;
  localparam logic [3:0] CNT_LOAD  = 4'(LATENCY - 1);
  localparam logic       LONG_WAIT = (LATENCY > 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_BUSY    = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  logic [1:0]           state;
  logic [1:0]           state_next;
  logic [3:0]           cnt;
  logic [ADDR_BITS-1:0] addr_l;
  logic [WORD_SIZE-1:0] wdata_l;
  logic                 op_read;
  logic                 drive_data;

  logic [WORD_SIZE-1:0] mem [DEPTH];

  // Request attributes as seen on the edge entering DONE. When coming
  // straight from IDLE (LATENCY == 1) the latches are not loaded yet, so
  // the live bus values are used instead.
  logic                 req_read;
  logic [ADDR_BITS-1:0] req_addr;
  logic [WORD_SIZE-1:0] req_wdata;
  logic                 enter_done;
  logic                 op_line;

  assign req_read   = (state == S_IDLE) ? readM : op_read;
  assign req_addr   = (state == S_IDLE) ? address[ADDR_BITS-1:0] : addr_l;
  assign req_wdata  = (state == S_IDLE) ? data : wdata_l;
  assign enter_done = (state_next == S_DONE);
  // Request line belonging to the latched operation; a conflict was latched
  // as a read, so readM governs it.
  assign op_line    = op_read ? readM : writeM;

  generate
    if (ADDR_BITS < WORD_SIZE) begin : g_addr_unused
      logic unused_addr_bits;
      assign unused_addr_bits = ^address[WORD_SIZE-1:ADDR_BITS];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (readM || writeM) begin
          state_next = LONG_WAIT ? S_BUSY : S_DONE;
        end
      end
      S_BUSY: begin
        // A dropped request line wins over completion on the same edge.
        if (!op_line) begin
          state_next = S_IDLE;
        end else if (cnt == 4'd0) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        state_next = S_RELEASE;
      end
      S_RELEASE: begin
        // Wait for the CPU to withdraw so one request gets one service.
        if (!readM && !writeM) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Combinational outputs
  // --------------------------------------------------------------------------
  always_comb begin
    busy       = (state != S_IDLE);
    // The word is put on the bus one cycle ahead of inputReady (last BUSY
    // cycle) so a consumer clocking on the rising pulse sees settled data.
    // Gating with readM releases the bus as soon as the CPU lets go.
    drive_data = op_read && readM &&
                 ((state == S_DONE) || (state == S_RELEASE) ||
                  ((state == S_BUSY) && (cnt == 4'd0)));
  end

  assign data = drive_data ? mem[addr_l] : {WORD_SIZE{1'bz}};

  // --------------------------------------------------------------------------
  // Request latches, latency counter, pulses and backing array
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt          <= 4'd0;
      addr_l       <= '0;
      wdata_l      <= '0;
      op_read      <= 1'b0;
      inputReady   <= 1'b0;
      ackOutput    <= 1'b0;
      req_conflict <= 1'b0;
    end else begin
      inputReady <= enter_done && req_read;
      ackOutput  <= enter_done && !req_read;

      // The array is not reset; keeping the write inside this block means
      // no write can land while reset is held.
      if (enter_done && !req_read) begin
        mem[req_addr] <= req_wdata;
      end

      case (state)
        S_IDLE: begin
          if (readM || writeM) begin
            addr_l  <= address[ADDR_BITS-1:0];
            wdata_l <= data;
            op_read <= readM;
            cnt     <= CNT_LOAD;
            if (readM && writeM) begin
              req_conflict <= 1'b1;
            end
          end
        end
        S_BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_ctrl
// Description : Self-checking bench for mem_port_ctrl. Two instances: A with
//               the default latency of 2, B with latency 4. Stimulus pushes
//               the expected completion (kind, word, cycle) into a per-DUT
//               queue; a negedge monitor pops and compares on every pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_ctrl;

  localparam int W     = 16;
  localparam int LAT_A = 2;
  localparam int LAT_B = 4;

  logic          clk   = 1'b0;
  logic          reset = 1'b1;
  logic          rd    = 1'b0;
  logic          wr    = 1'b0;
  logic          sel   = 1'b0;
  logic          oe    = 1'b0;
  logic [W-1:0]  addr  = '0;
  logic [W-1:0]  wd    = '0;

  wire  [W-1:0]  bus_a;
  wire  [W-1:0]  bus_b;
  logic          ir_a, ack_a, busy_a, rc_a;
  logic          ir_b, ack_b, busy_b, rc_b;

  assign bus_a = (oe && !sel) ? wd : {W{1'bz}};
  assign bus_b = (oe &&  sel) ? wd : {W{1'bz}};

  mem_port_ctrl #(.WORD_SIZE(W), .ADDR_BITS(8), .LATENCY(LAT_A)) dut_a (
    .clk(clk), .reset(reset), .readM(rd && !sel), .writeM(wr && !sel),
    .address(addr), .data(bus_a), .inputReady(ir_a), .ackOutput(ack_a),
    .busy(busy_a), .req_conflict(rc_a)
  );

  mem_port_ctrl #(.WORD_SIZE(W), .ADDR_BITS(8), .LATENCY(LAT_B)) dut_b (
    .clk(clk), .reset(reset), .readM(rd && sel), .writeM(wr && sel),
    .address(addr), .data(bus_b), .inputReady(ir_b), .ackOutput(ack_b),
    .busy(busy_b), .req_conflict(rc_b)
  );

  always #5 clk = ~clk;

  logic [31:0] cyc = '0;
  always @(posedge clk) cyc <= cyc + 32'd1;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic        rd;
    logic [15:0] d;
    logic [31:0] cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] cur_bus();
    return sel ? bus_b : bus_a;
  endfunction

  function automatic logic cur_busy();
    return sel ? busy_b : busy_a;
  endfunction

  // Undriven bus reads as all-Z in 4-state simulators and as zero in 2-state.
  task automatic chk_rel(input string name);
    logic [W-1:0] v;
    v = cur_bus();
    checks++;
    if (!((v === {W{1'bz}}) || (v === {W{1'b0}}))) begin
      failures++;
      $display("FAIL %s: got %h expected released bus (cycle %0d)", name, v, cyc);
    end
  endtask

  task automatic check_pulse(input string tag, input logic irv, input logic ackv,
                             input logic [W-1:0] bv, input exp_t e);
    chk({tag, "_kind"}, {30'd0, irv, ackv}, e.rd ? 32'd2 : 32'd1);
    chk({tag, "_cycle"}, cyc, e.cyc);
    if (e.rd) chk({tag, "_rdata"}, {16'd0, bv}, {16'd0, e.d});
  endtask

  // Monitor: every completion pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (ir_a || ack_a) begin
      if (qa.size() == 0) chk("dut_a_unexpected_pulse", {30'd0, ir_a, ack_a}, 32'd0);
      else check_pulse("dut_a", ir_a, ack_a, bus_a, qa.pop_front());
    end
    if (ir_b || ack_b) begin
      if (qb.size() == 0) chk("dut_b_unexpected_pulse", {30'd0, ir_b, ack_b}, 32'd0);
      else check_pulse("dut_b", ir_b, ack_b, bus_b, qb.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int lat_of(input logic s);
    return s ? LAT_B : LAT_A;
  endfunction

  task automatic push_exp(input logic s, input exp_t e);
    if (s) qb.push_back(e);
    else   qa.push_back(e);
  endtask

  task automatic do_write(input logic s, input logic [W-1:0] a, input logic [W-1:0] d);
    int lat;
    lat  = lat_of(s);
    sel  = s; addr = a; wd = d; oe = 1'b1; wr = 1'b1;
    push_exp(s, '{rd: 1'b0, d: d, cyc: cyc + 32'd1 + 32'(lat)});
    repeat (lat + 2) begin
      tick();
      chk("write_bus_not_driven_by_dut", {16'd0, cur_bus()}, {16'd0, d});
    end
    wr = 1'b0; oe = 1'b0;
    tick();
    chk("write_busy_after_release", {31'd0, cur_busy()}, 32'd0);
  endtask

  task automatic do_read(input logic s, input logic [W-1:0] a, input logic [W-1:0] exp,
                         input int hold, input logic both);
    int lat;
    lat  = lat_of(s);
    sel  = s; addr = a; rd = 1'b1; wr = both; oe = 1'b0;
    push_exp(s, '{rd: 1'b1, d: exp, cyc: cyc + 32'd1 + 32'(lat)});
    repeat (lat + 2) tick();
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("read_hold_data", {16'd0, cur_bus()}, {16'd0, exp});
    end
    rd = 1'b0; wr = 1'b0;
    #1;
    chk_rel("read_bus_released");
    tick();
    chk("read_busy_after_release", {31'd0, cur_busy()}, 32'd0);
  endtask

  initial begin
    // Reset state
    tick();
    chk("reset_inputReady", {31'd0, ir_a}, 32'd0);
    chk("reset_ackOutput",  {31'd0, ack_a}, 32'd0);
    chk("reset_busy",       {31'd0, busy_a}, 32'd0);
    chk("reset_conflict",   {31'd0, rc_a}, 32'd0);
    chk_rel("reset_bus");
    reset = 1'b0;
    tick();

    // Basic read after a preloading write
    do_write(1'b0, 16'h0005, 16'hBEEF);
    do_read (1'b0, 16'h0005, 16'hBEEF, 0, 1'b0);

    // Write then read back, with a long hold after completion
    do_write(1'b0, 16'h0012, 16'h1234);
    do_read (1'b0, 16'h0012, 16'h1234, 10, 1'b0);

    // Aliasing and conflicting requests
    chk("conflict_clear_before", {31'd0, rc_a}, 32'd0);
    do_write(1'b0, 16'h0103, 16'hC0DE);
    do_read (1'b0, 16'h0003, 16'hC0DE, 1, 1'b1);
    chk("conflict_set", {31'd0, rc_a}, 32'd1);
    do_read (1'b0, 16'h0003, 16'hC0DE, 0, 1'b0);
    chk("conflict_sticky", {31'd0, rc_a}, 32'd1);

    // Abort by dropping writeM one edge into BUSY (latency 4 instance)
    do_write(1'b1, 16'h0020, 16'h1111);
    sel = 1'b1; addr = 16'h0020; wd = 16'h2222; oe = 1'b1; wr = 1'b1;
    tick();
    chk("abort_busy_in_busy", {31'd0, busy_b}, 32'd1);
    wr = 1'b0; oe = 1'b0;
    tick();
    chk("abort_back_to_idle", {31'd0, busy_b}, 32'd0);
    repeat (6) tick();
    do_read(1'b1, 16'h0020, 16'h1111, 0, 1'b0);
    chk("dut_b_no_conflict", {31'd0, rc_b}, 32'd0);

    // Reset in the middle of a write
    sel = 1'b0; addr = 16'h0012; wd = 16'hAAAA; oe = 1'b1; wr = 1'b1;
    tick();
    chk("midreset_busy_before", {31'd0, busy_a}, 32'd1);
    reset = 1'b1;
    #1;
    chk("midreset_inputReady", {31'd0, ir_a}, 32'd0);
    chk("midreset_ackOutput",  {31'd0, ack_a}, 32'd0);
    chk("midreset_busy",       {31'd0, busy_a}, 32'd0);
    chk("midreset_conflict",   {31'd0, rc_a}, 32'd0);
    oe = 1'b0; wr = 1'b0;
    #1;
    chk_rel("midreset_bus");
    tick();
    tick();
    reset = 1'b0;
    tick();
    do_read(1'b0, 16'h0012, 16'h1234, 0, 1'b0);

    repeat (3) tick();
    chk("dut_a_queue_drained", qa.size(), 32'd0);
    chk("dut_b_queue_drained", qb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
